i2s_dma_scheduler: RTL and testbench

I2S_DMA_SCHEDULER -- requirements
Module: i2s_dma_scheduler

---
 rtl/i2s_dma_pkg.sv | 31 +++
 rtl/i2s_dma_scheduler.sv | 151 +++++++++++++++
 tb/tb_i2s_dma_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_dma_pkg.sv
// Shared types and constants for the I2S playback DMA command scheduler.
// Holds the FSM state encoding, the fixed burst size and the field positions
// of the datamover command word.
package i2s_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_STS,
        ST_HALT,
        ST_HALT_WAIT,
        ST_ERROR
    } state_t;

    // Bytes moved by every command (BURST_BYTES); the ring and period sizes are
    // multiples of this value.
    localparam int DM_BURST_BYTES = 64;

    // Command word field positions. The tag sits directly above the address,
    // so its LSB depends on the address width and is derived per instance.
    localparam int BTT_LSB  = 0;
    localparam int BTT_W    = 23;
    localparam int TYPE_BIT = 23;
    localparam int ADDR_LSB = 32;
    localparam int TAG_W    = 4;

    function automatic int tag_lsb(input int addr_width);
        return ADDR_LSB + addr_width;
    endfunction

endpackage

// File: rtl/i2s_dma_scheduler.sv
// Purpose: walks an audio ring buffer issuing one 64-byte datamover read command at a time, with period irqs.
// Latency: command presented the cycle after start or an accepted good status; irq one cycle after the status.
// Backpressure: cmd_tdata/cmd_tvalid hold while cmd_tready is low; one command outstanding until status returns.
//
// Ports: aclk/aresetn clock and async active-low reset; start/stop control pulses;
// buf_base/buf_bytes/period_bytes ring configuration sampled on start;
// cmd_* datamover command stream; sts_* datamover status stream;
// halt_dm/halt_complete_dm soft-shutdown handshake; running/period_irq/err/cur_addr status.
module i2s_dma_scheduler
    import i2s_dma_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int BURST_BYTES = 64
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     start,
    input  logic                     stop,
    input  logic [ADDR_WIDTH-1:0]    buf_base,
    input  logic [23:0]              buf_bytes,
    input  logic [23:0]              period_bytes,
    output logic                     cmd_tvalid,
    input  logic                     cmd_tready,
    output logic [40+ADDR_WIDTH-1:0] cmd_tdata,
    input  logic                     sts_tvalid,
    output logic                     sts_tready,
    input  logic [7:0]               sts_tdata,
    output logic                     halt_dm,
    input  logic                     halt_complete_dm,
    output logic                     running,
    output logic                     period_irq,
    output logic                     err,
    output logic [ADDR_WIDTH-1:0]    cur_addr
);

    localparam int TAG_LSB = tag_lsb(ADDR_WIDTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, end_q, addr_q;
    logic [23:0]           period_q, pcnt_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  err_q, irq_q;

    logic                  start_ok, sts_fire, sts_good;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [23:0]           pcnt_inc;

    // stop wins over a simultaneous start; start only counts from a parked state.
    assign start_ok = start && !stop && (state_q == ST_IDLE || state_q == ST_ERROR);
    assign sts_fire = sts_tvalid && sts_tready;
    assign sts_good = (sts_tdata[7:4] == 4'h0) && (sts_tdata[3:0] == tag_q);
    assign addr_inc = addr_q + ADDR_WIDTH'(BURST_BYTES);
    assign pcnt_inc = pcnt_q + 24'(BURST_BYTES);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_tvalid = 1'b0;
        sts_tready = 1'b0;
        halt_dm    = 1'b0;
        running    = 1'b1;
        unique case (state_q)
            ST_IDLE, ST_ERROR: begin
                running = 1'b0;
                if (start_ok) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                cmd_tvalid = 1'b1;
                // A stop racing the command handshake still halts; the halt
                // sequence flushes whatever the datamover accepted.
                if (stop)            state_d = ST_HALT;
                else if (cmd_tready) state_d = ST_WAIT_STS;
            end
            ST_WAIT_STS: begin
                sts_tready = 1'b1;
                if (stop)            state_d = ST_HALT;
                else if (sts_tvalid) state_d = sts_good ? ST_ISSUE : ST_HALT;
            end
            ST_HALT: begin
                sts_tready = 1'b1;
                halt_dm    = 1'b1;
                state_d    = ST_HALT_WAIT;
            end
            ST_HALT_WAIT: begin
                sts_tready = 1'b1;
                if (halt_complete_dm) state_d = err_q ? ST_ERROR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            base_q   <= '0;
            end_q    <= '0;
            addr_q   <= '0;
            period_q <= '0;
            pcnt_q   <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (start_ok) begin
                base_q   <= buf_base;
                end_q    <= buf_base + ADDR_WIDTH'(buf_bytes);
                period_q <= period_bytes;
                addr_q   <= buf_base;
                pcnt_q   <= '0;
                tag_q    <= '0;
                err_q    <= 1'b0;
            end
            if (state_q == ST_WAIT_STS && sts_fire) begin
                if (!sts_good) begin
                    err_q <= 1'b1;
                end else if (!stop) begin
                    // A good status coinciding with stop is dropped: the ring
                    // position is left at the burst that was in flight.
                    addr_q <= (addr_inc == end_q) ? base_q : addr_inc;
                    tag_q  <= tag_q + 1'b1;
                    if (pcnt_inc == period_q) begin
                        pcnt_q <= '0;
                        irq_q  <= 1'b1;
                    end else begin
                        pcnt_q <= pcnt_inc;
                    end
                end
            end
        end
    end

    always_comb begin
        cmd_tdata                             = '0;
        cmd_tdata[BTT_LSB +: BTT_W]           = BTT_W'(BURST_BYTES);
        cmd_tdata[TYPE_BIT]                   = 1'b1;
        cmd_tdata[ADDR_LSB +: ADDR_WIDTH]     = addr_q;
        cmd_tdata[TAG_LSB +: TAG_W]           = tag_q;
    end

    assign period_irq = irq_q;
    assign err        = err_q;
    assign cur_addr   = addr_q;

endmodule

// File: tb/tb_i2s_dma_scheduler.sv
// Bench for i2s_dma_scheduler: directed playback scenarios with a command/irq
// scoreboard, an automatic status responder, and direct checks on control outputs.
// Expected command words are built independently from address and tag.
module tb_i2s_dma_scheduler;

    localparam int AW = 64;
    localparam int CW = 40 + AW;

    logic          aclk = 1'b0;
    logic          aresetn, start, stop;
    logic [AW-1:0] buf_base;
    logic [23:0]   buf_bytes, period_bytes;
    logic          cmd_tvalid, cmd_tready;
    logic [CW-1:0] cmd_tdata;
    logic          sts_tvalid, sts_tready;
    logic [7:0]    sts_tdata;
    logic          halt_dm, halt_complete_dm;
    logic          running, period_irq, err;
    logic [AW-1:0] cur_addr;

    i2s_dma_scheduler #(.ADDR_WIDTH(AW), .BURST_BYTES(64)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
        .buf_base(buf_base), .buf_bytes(buf_bytes), .period_bytes(period_bytes),
        .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_tdata(cmd_tdata),
        .sts_tvalid(sts_tvalid), .sts_tready(sts_tready), .sts_tdata(sts_tdata),
        .halt_dm(halt_dm), .halt_complete_dm(halt_complete_dm),
        .running(running), .period_irq(period_irq), .err(err), .cur_addr(cur_addr)
    );

    always #5 aclk = ~aclk;

    logic [CW-1:0] cmd_q[$];
    int            irq_q[$];
    int            n_cmp = 0, n_err = 0;
    int            cmd_seen = 0, sts_cnt = 0, halt_cnt = 0;
    logic          auto_sts = 1'b0;
    int            err_tag = -1;
    int            inj_req = 0, inj_done = 0;
    logic [7:0]    inj_dat = 8'h00;
    logic [3:0]    rsp_tag;

    function automatic logic [CW-1:0] exp_cmd(input logic [AW-1:0] a, input logic [3:0] t);
        return {4'h0, t, a, 8'h00, 1'b1, 23'd64};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a command or irq.
    initial forever begin
        @(negedge aclk);
        if (cmd_tvalid && cmd_tready) begin
            cmd_seen++;
            if (cmd_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_cmd: got 0x%0h, expected no command", cmd_tdata);
            end else begin
                check("cmd_word", cmd_tdata, cmd_q.pop_front());
            end
        end
        if (sts_tvalid && sts_tready) sts_cnt++;
        if (halt_dm) halt_cnt++;
        if (period_irq) begin
            if (irq_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_irq: got irq after status %0d, expected none", sts_cnt);
            end else begin
                check("irq_at_status", sts_cnt, irq_q.pop_front());
            end
        end
    end

    task automatic drive_sts(input logic [7:0] d);
        @(posedge aclk); #1;
        sts_tvalid = 1'b1;
        sts_tdata  = d;
        for (int g = 0; g < 50; g++) begin
            @(negedge aclk);
            if (sts_tready) break;
        end
        @(posedge aclk); #1;
        sts_tvalid = 1'b0;
    endtask

    // Datamover status responder: answers each command with its own tag,
    // or with 0x53 for the tag selected by err_tag; also serves injected statuses.
    initial begin
        sts_tvalid = 1'b0;
        sts_tdata  = 8'h00;
        forever begin
            @(negedge aclk);
            if (inj_req != inj_done) begin
                inj_done++;
                drive_sts(inj_dat);
            end else if (auto_sts && cmd_tvalid && cmd_tready) begin
                rsp_tag = cmd_tdata[AW+32 +: 4];
                drive_sts((int'(rsp_tag) == err_tag) ? 8'h53 : {4'h0, rsp_tag});
            end
        end
    end

    task automatic tick();
        @(posedge aclk); #1;
    endtask

    task automatic do_start(input logic [AW-1:0] a, input logic [23:0] b, input logic [23:0] p);
        buf_base = a; buf_bytes = b; period_bytes = p;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_cmds(input int target, input string name);
        int g = 0;
        while (cmd_seen < target && g < 400) begin
            @(posedge aclk);
            g++;
        end
        #1;
        check(name, cmd_seen, target);
    endtask

    task automatic finish_halt(input int exp_halt, input logic exp_err, input string name);
        int g = 0;
        while (halt_cnt < exp_halt && g < 100) begin
            tick();
            g++;
        end
        repeat (3) tick();
        check({name, "_halt_pulses"}, halt_cnt, exp_halt);
        check({name, "_running_in_halt_wait"}, running, 1'b1);
        halt_complete_dm = 1'b1;
        tick();
        halt_complete_dm = 1'b0;
        check({name, "_running_after_halt"}, running, 1'b0);
        check({name, "_err_after_halt"}, err, exp_err);
        check({name, "_cmd_tvalid_after_halt"}, cmd_tvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb, hb, cb;
        aresetn = 1'b0; start = 1'b0; stop = 1'b0;
        buf_base = '0; buf_bytes = '0; period_bytes = '0;
        cmd_tready = 1'b1; halt_complete_dm = 1'b0;

        // Reset state
        #2;
        check("rst_cmd_tvalid", cmd_tvalid, 1'b0);
        check("rst_sts_tready", sts_tready, 1'b0);
        check("rst_halt_dm",    halt_dm,    1'b0);
        check("rst_running",    running,    1'b0);
        check("rst_period_irq", period_irq, 1'b0);
        check("rst_err",        err,        1'b0);
        check("rst_cur_addr",   cur_addr,   64'h0);
        repeat (3) tick();
        aresetn = 1'b1;
        tick();

        // Basic ring walk with wrap and irq every two statuses
        auto_sts = 1'b1;
        sb = sts_cnt; hb = halt_cnt; cb = cmd_seen;
        cmd_q.push_back(exp_cmd(64'h1000, 4'd0));
        cmd_q.push_back(exp_cmd(64'h1040, 4'd1));
        cmd_q.push_back(exp_cmd(64'h1080, 4'd2));
        cmd_q.push_back(exp_cmd(64'h10C0, 4'd3));
        cmd_q.push_back(exp_cmd(64'h1000, 4'd4));
        irq_q.push_back(sb + 2);
        irq_q.push_back(sb + 4);
        do_start(64'h1000, 24'd256, 24'd128);
        check("ring_running", running, 1'b1);
        wait_cmds(cb + 5, "ring_cmd_count");
        pulse_stop();
        finish_halt(hb + 1, 1'b0, "ring");
        check("ring_irq_all_seen", irq_q.size(), 0);

        // Tag wrap over 17 commands, 8-entry ring, irq on every full ring
        sb = sts_cnt; hb = halt_cnt; cb = cmd_seen;
        for (int i = 0; i < 17; i++)
            cmd_q.push_back(exp_cmd(64'((i % 8) * 64), 4'(i % 16)));
        irq_q.push_back(sb + 8);
        irq_q.push_back(sb + 16);
        do_start(64'h0, 24'h200, 24'h200);
        wait_cmds(cb + 17, "wrap_cmd_count");
        check("wrap_err", err, 1'b0);
        pulse_stop();
        finish_halt(hb + 1, 1'b0, "wrap");
        check("wrap_irq_all_seen", irq_q.size(), 0);

        // Error status 0x53 returned for the tag-3 command
        sb = sts_cnt; hb = halt_cnt; cb = cmd_seen;
        err_tag = 3;
        for (int i = 0; i < 4; i++)
            cmd_q.push_back(exp_cmd(64'h2000 + 64'(i * 64), 4'(i)));
        irq_q.push_back(sb + 2);
        do_start(64'h2000, 24'h400, 24'h080);
        wait_cmds(cb + 4, "errsts_cmd_count");
        repeat (4) tick();
        check("errsts_err_set", err, 1'b1);
        finish_halt(hb + 1, 1'b1, "errsts");
        err_tag = -1;
        repeat (4) tick();
        check("errsts_error_state_idle", running, 1'b0);

        // Stop in WAIT_STS with status withheld; late status is discarded
        auto_sts = 1'b0;
        hb = halt_cnt; cb = cmd_seen; sb = sts_cnt;
        cmd_q.push_back(exp_cmd(64'h3000, 4'd0));
        do_start(64'h3000, 24'h100, 24'h040);
        check("stop_start_clears_err", err, 1'b0);
        wait_cmds(cb + 1, "stop_cmd_count");
        repeat (3) tick();
        check("stop_sts_tready_waiting", sts_tready, 1'b1);
        pulse_stop();
        inj_dat = 8'h00;
        inj_req++;
        for (int g = 0; g < 50 && sts_cnt == sb; g++) tick();
        check("stop_sts_consumed", sts_cnt, sb + 1);
        check("stop_addr_not_advanced", cur_addr, 64'h3000);
        finish_halt(hb + 1, 1'b0, "stop");

        // Command held under cmd_tready low for 10 cycles
        hb = halt_cnt; cb = cmd_seen;
        cmd_tready = 1'b0;
        cmd_q.push_back(exp_cmd(64'h4000, 4'd0));
        do_start(64'h4000, 24'h100, 24'h100);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check("stall_tvalid", cmd_tvalid, 1'b1);
            check("stall_tdata", cmd_tdata, exp_cmd(64'h4000, 4'd0));
        end
        tick();
        cmd_tready = 1'b1;
        wait_cmds(cb + 1, "stall_cmd_accepted");
        pulse_stop();
        finish_halt(hb + 1, 1'b0, "stall");
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        check("startstop_running", running, 1'b0);
        check("startstop_cmd_tvalid", cmd_tvalid, 1'b0);

        // Asynchronous reset while a command is stalled in ISSUE
        cmd_tready = 1'b0;
        do_start(64'h6000, 24'h100, 24'h100);
        tick(); tick();
        check("prerst_cmd_tvalid", cmd_tvalid, 1'b1);
        check("prerst_cur_addr", cur_addr, 64'h6000);
        #3 aresetn = 1'b0;
        #1;
        check("arst_cmd_tvalid", cmd_tvalid, 1'b0);
        check("arst_running",    running,    1'b0);
        check("arst_cur_addr",   cur_addr,   64'h0);
        check("arst_sts_tready", sts_tready, 1'b0);
        check("arst_halt_dm",    halt_dm,    1'b0);
        tick(); tick();
        aresetn = 1'b1;
        cmd_tready = 1'b1;
        auto_sts = 1'b1;
        tick();
        sb = sts_cnt; hb = halt_cnt; cb = cmd_seen;
        cmd_q.push_back(exp_cmd(64'h7000, 4'd0));
        cmd_q.push_back(exp_cmd(64'h7040, 4'd1));
        irq_q.push_back(sb + 1);
        do_start(64'h7000, 24'h080, 24'h040);
        wait_cmds(cb + 2, "resume_cmd_count");
        pulse_stop();
        finish_halt(hb + 1, 1'b0, "resume");

        repeat (5) tick();
        check("final_cmd_queue_empty", cmd_q.size(), 0);
        check("final_irq_queue_empty", irq_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
